// File: rtl/freoff_seq_if.sv
// Handshake bundle between timing sync, the frequency-offset datapath and the sequencer.
// The sequencer uses the slave modport; the upstream/test side uses master.
interface freoff_seq_if;
  logic       ce;
  logic       sync_det;
  logic       stb_in;
  logic       est_rdy;
  logic       out_val;
  logic       est_ena;
  logic       comp_run;
  logic       sym_start;
  logic [7:0] sym_idx;
  logic       busy;
  logic       done;
  logic       err_tmo;

  modport master (
    output ce, sync_det, stb_in, est_rdy, out_val,
    input  est_ena, comp_run, sym_start, sym_idx, busy, done, err_tmo
  );

  modport slave (
    input  ce, sync_det, stb_in, est_rdy, out_val,
    output est_ena, comp_run, sym_start, sym_idx, busy, done, err_tmo
  );
endinterface

// File: rtl/freoff_seq.sv
// Frequency-offset estimate/compensate sequencer: IDLE -> EST -> COMP -> FLUSH -> IDLE.
// Optional macro FREOFF_SEQ_RESYNC_EN: sync_det in COMP/FLUSH aborts via a one-cycle RESYNC state.
module freoff_seq #(
  parameter int unsigned SYM_LEN   = 2560,
  parameter int unsigned NUM_SYM   = 8,
  parameter int unsigned EST_TMO   = 256,
  parameter int unsigned FLUSH_LEN = 32
) (
  input logic        clk,
  input logic        rst,
  freoff_seq_if.slave bus
);

  localparam int unsigned SmpW = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
  localparam int unsigned TmoW = (EST_TMO > 1) ? $clog2(EST_TMO) : 1;
  localparam int unsigned FlsW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

  localparam logic [SmpW-1:0] SmpLast = SmpW'(SYM_LEN - 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(EST_TMO - 1);
  localparam logic [FlsW-1:0] FlsLast = FlsW'(FLUSH_LEN - 1);
  localparam logic [7:0]      SymLast = 8'(NUM_SYM - 1);

  typedef enum logic [2:0] {
    StIdle,
    StEst,
    StComp,
    StFlush
`ifdef FREOFF_SEQ_RESYNC_EN
    , StResync
`endif
  } state_e;

  state_e          state_q;
  logic [SmpW-1:0] smp_cnt_q;
  logic [TmoW-1:0] tmo_cnt_q;
  logic [FlsW-1:0] flush_cnt_q;
  logic            est_ena_q;
  logic            comp_run_q;
  logic            sym_start_q;
  logic [7:0]      sym_idx_q;
  logic            busy_q;
  logic            done_q;
  logic            err_tmo_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      smp_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      flush_cnt_q <= '0;
      est_ena_q   <= 1'b0;
      comp_run_q  <= 1'b0;
      sym_start_q <= 1'b0;
      sym_idx_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_tmo_q   <= 1'b0;
    end else begin
      // Pulses last one clk even when ce stalls the FSM.
      sym_start_q <= 1'b0;
      done_q      <= 1'b0;
      if (bus.ce) begin
        unique case (state_q)
          StIdle: begin
            if (bus.sync_det) begin
              state_q   <= StEst;
              est_ena_q <= 1'b1;
              busy_q    <= 1'b1;
              err_tmo_q <= 1'b0;
              tmo_cnt_q <= '0;
            end
          end
          StEst: begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
            if (bus.est_rdy) begin
              state_q    <= StComp;
              comp_run_q <= 1'b1;
              smp_cnt_q  <= '0;
              sym_idx_q  <= '0;
            end else if (tmo_cnt_q == TmoLast) begin
              state_q   <= StIdle;
              est_ena_q <= 1'b0;
              busy_q    <= 1'b0;
              err_tmo_q <= 1'b1;
            end
          end
          StComp: begin
`ifdef FREOFF_SEQ_RESYNC_EN
            if (bus.sync_det) begin
              state_q    <= StResync;
              est_ena_q  <= 1'b0;
              comp_run_q <= 1'b0;
              sym_idx_q  <= '0;
              smp_cnt_q  <= '0;
            end else
`endif
            if (bus.stb_in) begin
              sym_start_q <= (smp_cnt_q == '0);
              if (smp_cnt_q == SmpLast) begin
                smp_cnt_q <= '0;
                if (sym_idx_q == SymLast) begin
                  state_q     <= StFlush;
                  flush_cnt_q <= '0;
                end else begin
                  sym_idx_q <= sym_idx_q + 8'd1;
                end
              end else begin
                smp_cnt_q <= smp_cnt_q + 1'b1;
              end
            end
          end
          StFlush: begin
`ifdef FREOFF_SEQ_RESYNC_EN
            if (bus.sync_det) begin
              state_q    <= StResync;
              est_ena_q  <= 1'b0;
              comp_run_q <= 1'b0;
              sym_idx_q  <= '0;
              smp_cnt_q  <= '0;
            end else
`endif
            if (bus.out_val) begin
              if (flush_cnt_q == FlsLast) begin
                state_q    <= StIdle;
                done_q     <= 1'b1;
                est_ena_q  <= 1'b0;
                comp_run_q <= 1'b0;
                sym_idx_q  <= '0;
                busy_q     <= 1'b0;
              end else begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
              end
            end
          end
`ifdef FREOFF_SEQ_RESYNC_EN
          StResync: begin
            // est_ena was low for this cycle, so the datapath sees a fresh rising edge.
            state_q   <= StEst;
            est_ena_q <= 1'b1;
            tmo_cnt_q <= '0;
          end
`endif
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.est_ena   = est_ena_q;
  assign bus.comp_run  = comp_run_q;
  assign bus.sym_start = sym_start_q;
  assign bus.sym_idx   = sym_idx_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err_tmo   = err_tmo_q;

endmodule

// File: doc/freoff_seq.md
Name: freoff_seq

Overview:
- Sequencer for the frequency-offset estimate/compensate datapath in the 802.22 OFDM receiver.
- On a timing-sync pulse it opens the estimator enable window and waits for the phase estimate.
- It then keeps compensation running for a fixed number of OFDM symbols while reporting symbol boundaries, and closes the window after the rotator pipeline drains.
- It sits between timing sync (upstream) and the CP-removal/FFT stage (downstream).

Parameters:
SYM_LEN, 2560, samples per OFDM symbol including CP (2048 + 512)
NUM_SYM, 8, symbols compensated per burst (1..255)
EST_TMO, 256, max clk cycles in EST waiting for est_rdy
FLUSH_LEN, 32, out_val-qualified drain count after last input sample

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low (0 = reset)
ce  in  1  clock enable; counters and FSM advance only when ce=1
sync_det  in  1  one-cycle pulse: preamble timing located
stb_in  in  1  input sample strobe (same strobe fed to the datapath)
est_rdy  in  1  one-cycle pulse: phase estimate loaded into accumulator
out_val  in  1  compensated sample valid from datapath
est_ena  out  1  drives datapath ena; rising edge starts estimation
comp_run  out  1  high while compensated samples are forwarded downstream
sym_start  out  1  one-cycle pulse on the first input strobe of each symbol
sym_idx  out  8  index of the current symbol, 0..NUM_SYM-1
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at burst completion
err_tmo  out  1  sticky; set on estimator timeout, cleared by a new sync_det in IDLE

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE. All outputs 0. All counters 0. Reset overrides ce and every other input, in any state.
- FSM states: IDLE, EST, COMP, FLUSH. All transitions and counter updates require ce=1, except that reset ignores ce.
- IDLE:
  - est_ena=0.
  - sync_det=1 -> EST; est_ena=1 from the next cycle; err_tmo cleared on the same edge; tmo_cnt=0.
- EST:
  - est_ena=1; tmo_cnt increments every ce cycle.
  - est_rdy=1 -> COMP; smp_cnt=0, sym_idx=0.
  - If tmo_cnt reaches EST_TMO-1 with no est_rdy -> IDLE; est_ena=0 next cycle; err_tmo=1; no done pulse.
  - est_rdy and the timeout on the same cycle: est_rdy wins.
  - sync_det in EST is ignored.
- COMP:
  - est_ena=1; comp_run=1.
  - Each stb_in=1 increments smp_cnt. sym_start=1 on the same cycle as a strobe with smp_cnt==0.
  - Strobe with smp_cnt==SYM_LEN-1: smp_cnt wraps to 0. If sym_idx==NUM_SYM-1 -> FLUSH; otherwise sym_idx increments.
- FLUSH:
  - est_ena=1 and comp_run=1 held; flush_cnt counts out_val pulses.
  - flush_cnt==FLUSH_LEN-1 with out_val=1 -> IDLE; done=1 for one cycle; est_ena, comp_run and sym_idx all 0 on that edge.
  - stb_in in FLUSH is ignored.
- sync_det in COMP/FLUSH: ignored unless the optional feature is enabled.
- est_ena always falls for at least one cycle between bursts, so the datapath sees a fresh rising edge on the next burst.
- Counter widths: smp_cnt sized by clog2(SYM_LEN); tmo_cnt by clog2(EST_TMO); flush_cnt by clog2(FLUSH_LEN). No counter overflows under legal parameters.
- All outputs registered. Latency sync_det -> est_ena = 1 ce cycle.

Optional Feature:
- Macro FREOFF_SEQ_RESYNC_EN.
- Defined: sync_det=1 in COMP or FLUSH aborts the burst.
  - est_ena=0 and comp_run=0 for exactly one ce cycle (internal state RESYNC), then EST with tmo_cnt=0.
  - No done pulse; sym_idx resets to 0.
- Not defined: sync_det outside IDLE has no effect; the RESYNC state is not built.

Test Plan:
- Nominal burst, SYM_LEN=16, NUM_SYM=2, FLUSH_LEN=4: sync_det, est_rdy 20 cycles later, continuous stb_in, out_val continuous -> sym_start pulses at strobes 0 and 16; sym_idx 0 then 1; 4 out_val pulses after strobe 31, then done=1 once; est_ena=0 next cycle.
- Timeout, EST_TMO=8: sync_det, no est_rdy -> est_ena high for 8 cycles; err_tmo=1 sticky; busy=0; no done. A new sync_det clears err_tmo.
- Gapped strobes (stb_in every 3rd cycle), ce toggling 50% -> sym_start only on qualified strobes; counts identical to the nominal case.
- Reset mid-COMP (rst=0 at sym_idx=1) -> next cycle all outputs 0, state IDLE. A following sync_det starts a clean burst with sym_idx=0.
- est_rdy coincident with the last timeout cycle -> enters COMP; err_tmo stays 0.
- With FREOFF_SEQ_RESYNC_EN: sync_det at sym_idx=1 -> est_ena low for 1 cycle then high; sym_idx=0; no done. Without the macro: same stimulus -> burst completes normally with done=1.
